// File: rtl/imem_loader_if.sv
// Host byte stream, core fetch port and instruction-memory port of the loader.
// The controller uses the slave view; the environment (host, core, memory) uses master.
interface imem_loader_if #(
   parameter int ADDR_W = 10
);
   logic              load_start;
   logic              run_start;
   logic [ADDR_W:0]   load_len;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              fetch_req;
   logic [31:0]       fetch_pc;
   logic              fetch_valid;
   logic [31:0]       fetch_instr;
   logic              fetch_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_we;
   logic [31:0]       mem_rdata;
   logic              cpu_hold;
   logic              load_done;

   modport slave (
      input  load_start, run_start, load_len, byte_valid, byte_data,
             fetch_req, fetch_pc, mem_rdata,
      output byte_ready, fetch_valid, fetch_instr, fetch_err,
             mem_addr, mem_wdata, mem_we, cpu_hold, load_done
   );

   modport master (
      output load_start, run_start, load_len, byte_valid, byte_data,
             fetch_req, fetch_pc, mem_rdata,
      input  byte_ready, fetch_valid, fetch_instr, fetch_err,
             mem_addr, mem_wdata, mem_we, cpu_hold, load_done
   );
endinterface

// File: rtl/imem_loader_ctrl.sv
// Instruction-memory owner: loads a program from a host byte stream into memory,
// then releases the core and serves its fetches with one cycle of registered latency.
module imem_loader_ctrl #(
   parameter int          ADDR_W = 10,
   parameter logic [31:0] NOP    = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          reset_n,
   imem_loader_if.slave  bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_RUN  = 2'd3;

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0]      r_state, w_state_nxt;
   logic [ADDR_W:0] r_len;
   logic [ADDR_W:0] r_word_cnt;   // words already written
   logic [ADDR_W:0] r_words_rx;   // words fully assembled (written or being written)
   logic [1:0]      r_byte_cnt;
   logic [23:0]     r_acc;
   logic            r_we;
   logic [31:0]     r_wdata;
   logic            r_fvalid, r_ferr;
   logic [31:0]     r_finstr;

   logic            w_start_load, w_byte_ready, w_byte_xfer, w_last_write, w_fault;
   logic [ADDR_W:0] w_len_clamp;

   // Clamping keeps the word address inside the memory, so it never wraps.
   assign w_len_clamp  = (bus.load_len > DEPTH) ? DEPTH : bus.load_len;
   assign w_start_load = bus.load_start && ((r_state == S_IDLE) || (r_state == S_RUN));
   assign w_byte_ready = (r_state == S_LOAD) && (r_words_rx < r_len);
   assign w_byte_xfer  = bus.byte_valid && w_byte_ready;
   assign w_last_write = r_we && ((r_word_cnt + ONE) == r_len);
   assign w_fault      = (|bus.fetch_pc[1:0]) || (|bus.fetch_pc[31:ADDR_W+2]);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.load_start)     w_state_nxt = S_LOAD;
            else if (bus.run_start) w_state_nxt = S_RUN;
         end
         S_LOAD: if ((r_len == '0) || w_last_write) w_state_nxt = S_DONE;
         S_DONE: w_state_nxt = S_RUN;
         S_RUN:  if (bus.load_start) w_state_nxt = S_LOAD;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Load datapath: the accumulator holds bytes 0..2, byte 3 completes the word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_len      <= '0;
         r_word_cnt <= '0;
         r_words_rx <= '0;
         r_byte_cnt <= '0;
         r_acc      <= '0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
      end else begin
         r_we <= w_byte_xfer && (r_byte_cnt == 2'd3);
         if (w_start_load) begin
            r_len      <= w_len_clamp;
            r_word_cnt <= '0;
            r_words_rx <= '0;
            r_byte_cnt <= '0;
            r_acc      <= '0;
         end else if (r_state == S_LOAD) begin
            if (w_byte_xfer) begin
               r_byte_cnt <= r_byte_cnt + 2'd1;
               case (r_byte_cnt)
                  2'd0: r_acc[7:0]   <= bus.byte_data;
                  2'd1: r_acc[15:8]  <= bus.byte_data;
                  2'd2: r_acc[23:16] <= bus.byte_data;
                  default: begin
                     r_wdata    <= {bus.byte_data, r_acc};
                     r_words_rx <= r_words_rx + ONE;
                  end
               endcase
            end
            if (r_we) r_word_cnt <= r_word_cnt + ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fvalid <= 1'b0;
         r_ferr   <= 1'b0;
         r_finstr <= '0;
      end else if ((r_state == S_RUN) && bus.fetch_req) begin
         r_fvalid <= 1'b1;
         r_ferr   <= w_fault;
         r_finstr <= w_fault ? NOP : bus.mem_rdata;
      end else begin
         r_fvalid <= 1'b0;
         r_ferr   <= 1'b0;
      end
   end

   always_comb begin
      bus.mem_addr = '0;
      if (r_state == S_LOAD)
         bus.mem_addr = r_word_cnt[ADDR_W-1:0];
      else if ((r_state == S_RUN) && bus.fetch_req)
         bus.mem_addr = bus.fetch_pc[ADDR_W+1:2];
   end

   assign bus.byte_ready  = w_byte_ready;
   assign bus.mem_we      = r_we;
   assign bus.mem_wdata   = r_wdata;
   assign bus.fetch_valid = r_fvalid;
   assign bus.fetch_err   = r_ferr;
   assign bus.fetch_instr = r_finstr;
   assign bus.cpu_hold    = (r_state != S_RUN);
   assign bus.load_done   = (r_state == S_DONE);
endmodule
